// File: rtl/seq_arith_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the
// sequential arithmetic unit and its multiplier.
package seq_arith_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_ADC = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SBB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int FLAG_C     = 0;
   localparam int FLAG_Z     = 1;
   localparam int FLAG_N     = 2;
   localparam int FLAG_V     = 3;
   localparam int FLAG_COUNT = 4;

endpackage

// File: rtl/seq_mul_shift_add.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first step is folded into the start edge, so done follows WIDTH steps.
module seq_mul_shift_add #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(WIDTH - 1);

   logic [WIDTH-1:0]   mcand_reg;
   logic [WIDTH-1:0]   count_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic               busy_reg;
   logic               done_reg;

   // High half accumulates the partial sum, low half holds unconsumed multiplier bits.
   function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] s;
      s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {s, p[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg <= '0;
         count_reg <= '0;
         prod_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (busy_reg) begin
            prod_reg  <= step(prod_reg, mcand_reg);
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_COUNT) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end else if (start) begin
            mcand_reg <= a;
            prod_reg  <= step({{WIDTH{1'b0}}, b}, a);
            count_reg <= WIDTH'(1);
            busy_reg  <= 1'b1;
         end
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = prod_reg;

endmodule

// File: rtl/seq_arith_unit.sv
// Registered add/adc/sub/sbb/cmp unit with C/Z/N/V flags and an optional
// iterative unsigned multiplier behind a valid/ready request handshake.
module seq_arith_unit
   import seq_arith_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iValid,
   output logic             oReady,
   input  logic [2:0]       iOpcode,
   input  logic [WIDTH-1:0] iPortA,
   input  logic [WIDTH-1:0] iPortB,
   output logic [WIDTH-1:0] oAccumulator,
   output logic [WIDTH-1:0] oAccHigh,
   output logic             oDone,
   output logic             oCarry,
   output logic             oZero,
   output logic             oNeg,
   output logic             oOvf
);

   state_t                  state_reg;
   logic                    ready_reg;
   logic                    done_reg;
   logic [WIDTH-1:0]        acc_reg;
   logic [WIDTH-1:0]        high_reg;
   logic [FLAG_COUNT-1:0]   flags_reg;

   logic                    accept;
   logic                    mul_start;
   logic                    mul_busy;
   logic                    mul_done;
   logic [2*WIDTH-1:0]      mul_product;

   logic [WIDTH:0]          sum;
   logic [WIDTH:0]          diff;
   logic                    adc_cin;
   logic                    sbb_cin;
   logic [WIDTH-1:0]        alu_result;
   logic [FLAG_COUNT-1:0]   alu_flags;
   logic                    writes_acc;
   logic                    writes_flags;
   logic [FLAG_COUNT-1:0]   mul_flags;

   assign accept    = iValid & ready_reg;
   assign mul_start = MUL_EN && accept && (iOpcode == OP_MUL) && !mul_busy;

   // Carry-in comes from the registered flag, not from any in-flight result.
   assign adc_cin = (iOpcode == OP_ADC) & flags_reg[FLAG_C];
   assign sbb_cin = (iOpcode == OP_SBB) & flags_reg[FLAG_C];
   assign sum     = {1'b0, iPortA} + {1'b0, iPortB} + (WIDTH+1)'(adc_cin);
   assign diff    = {1'b0, iPortA} - {1'b0, iPortB} - (WIDTH+1)'(sbb_cin);

   always_comb begin
      alu_result   = '0;
      alu_flags    = '0;
      writes_acc   = 1'b0;
      writes_flags = 1'b0;
      case (iOpcode)
         OP_ADD, OP_ADC: begin
            alu_result        = sum[WIDTH-1:0];
            alu_flags[FLAG_C] = sum[WIDTH];
            alu_flags[FLAG_V] = (iPortA[WIDTH-1] == iPortB[WIDTH-1]) &&
                                (sum[WIDTH-1] != iPortA[WIDTH-1]);
            writes_acc        = 1'b1;
            writes_flags      = 1'b1;
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            alu_result        = diff[WIDTH-1:0];
            alu_flags[FLAG_C] = diff[WIDTH];
            alu_flags[FLAG_V] = (iPortA[WIDTH-1] != iPortB[WIDTH-1]) &&
                                (diff[WIDTH-1] != iPortA[WIDTH-1]);
            writes_acc        = (iOpcode != OP_CMP);
            writes_flags      = 1'b1;
         end
         default: ;
      endcase
      alu_flags[FLAG_Z] = (alu_result == '0);
      alu_flags[FLAG_N] = alu_result[WIDTH-1];
   end

   always_comb begin
      mul_flags         = '0;
      mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
      mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
      mul_flags[FLAG_Z] = (mul_product == '0);
      mul_flags[FLAG_N] = mul_product[WIDTH-1];
   end

   generate
      if (MUL_EN) begin : g_mul
         seq_mul_shift_add #(.WIDTH(WIDTH)) u_mul (
            .clk     (iClock),
            .rst_n   (iReset),
            .start   (mul_start),
            .a       (iPortA),
            .b       (iPortB),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_busy    = 1'b0;
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_reg <= ST_IDLE;
         ready_reg <= 1'b1;
         done_reg  <= 1'b0;
         acc_reg   <= '0;
         high_reg  <= '0;
         flags_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (mul_start) begin
                  state_reg <= ST_MUL;
                  ready_reg <= 1'b0;
               end else if (accept) begin
                  // Every other opcode, including NOP and MUL with no multiplier, completes here.
                  done_reg <= 1'b1;
                  if (writes_acc)
                     acc_reg <= alu_result;
                  if (writes_flags)
                     flags_reg <= alu_flags;
               end
            end
            ST_MUL: begin
               if (mul_done)
                  state_reg <= ST_DONE;
            end
            ST_DONE: begin
               acc_reg   <= mul_product[WIDTH-1:0];
               high_reg  <= mul_product[2*WIDTH-1:WIDTH];
               flags_reg <= mul_flags;
               done_reg  <= 1'b1;
               ready_reg <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign oReady       = ready_reg;
   assign oDone        = done_reg;
   assign oAccumulator = acc_reg;
   assign oAccHigh     = high_reg;
   assign oCarry       = flags_reg[FLAG_C];
   assign oZero        = flags_reg[FLAG_Z];
   assign oNeg         = flags_reg[FLAG_N];
   assign oOvf         = flags_reg[FLAG_V];

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: ALU chain, MUL timing, reset mid-MUL,
// and a MUL_EN=0 instance sharing the same stimulus.
module tb_seq_arith_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [2:0]  op;
   logic [15:0] a;
   logic [15:0] b;

   logic        ready, done, c_f, z_f, n_f, v_f;
   logic [15:0] acc, hi;
   logic        ready_d, done_d, c_d, z_d, n_d, v_d;
   logic [15:0] acc_d, hi_d;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_arith_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .iClock(clk), .iReset(rst_n), .iValid(valid), .oReady(ready),
      .iOpcode(op), .iPortA(a), .iPortB(b),
      .oAccumulator(acc), .oAccHigh(hi), .oDone(done),
      .oCarry(c_f), .oZero(z_f), .oNeg(n_f), .oOvf(v_f)
   );

   seq_arith_unit #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (
      .iClock(clk), .iReset(rst_n), .iValid(valid), .oReady(ready_d),
      .iOpcode(op), .iPortA(a), .iPortB(b),
      .oAccumulator(acc_d), .oAccHigh(hi_d), .oDone(done_d),
      .oCarry(c_d), .oZero(z_d), .oNeg(n_d), .oOvf(v_d)
   );

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] acc;
      logic [3:0]  fl;   // {V,N,Z,C}
   } vec_t;

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; op = 3'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({acc, hi, done, v_f, n_f, z_f, c_f} !== 37'd0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_values acc=%h hi=%h done=%b flags=%b%b%b%b ready=%b required all 0, ready=1",
                  acc, hi, done, v_f, n_f, z_f, c_f, ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || acc !== 16'h0000) begin
         failures++;
         $display("FAIL post_reset_idle done=%b ready=%b acc=%h required 0/1/0000", done, ready, acc);
      end
   endtask

   task automatic test_alu_chain();
      vec_t vecs[9];
      vecs[0] = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011};
      vecs[1] = '{3'b010, 16'h0001, 16'h0001, 16'h0003, 4'b0000};
      vecs[2] = '{3'b011, 16'h0000, 16'h0001, 16'hFFFF, 4'b0101};
      vecs[3] = '{3'b100, 16'h0005, 16'h0002, 16'h0002, 4'b0000};
      vecs[4] = '{3'b110, 16'h8000, 16'h0001, 16'h0002, 4'b1000};
      vecs[5] = '{3'b000, 16'h1111, 16'h2222, 16'h0002, 4'b1000};
      vecs[6] = '{3'b111, 16'h0000, 16'h0000, 16'h0002, 4'b1000};
      vecs[7] = '{3'b001, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100};
      vecs[8] = '{3'b011, 16'h8000, 16'h8000, 16'h0000, 4'b0010};
      for (int i = 0; i < 9; i++) begin
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; valid = 1'b1;
         @(negedge clk);
         $display("alu op=%0d a=%h b=%h -> acc=%h VNZC=%b%b%b%b done=%b",
                  vecs[i].op, vecs[i].a, vecs[i].b, acc, v_f, n_f, z_f, c_f, done);
         checks++;
         if (acc !== vecs[i].acc) begin
            failures++;
            $display("FAIL alu_acc[%0d] got=%h required=%h", i, acc, vecs[i].acc);
         end
         checks++;
         if ({v_f, n_f, z_f, c_f} !== vecs[i].fl) begin
            failures++;
            $display("FAIL alu_flags[%0d] got VNZC=%b%b%b%b required=%b", i, v_f, n_f, z_f, c_f, vecs[i].fl);
         end
         checks++;
         if (done !== 1'b1 || ready !== 1'b1 || hi !== 16'h0000) begin
            failures++;
            $display("FAIL alu_handshake[%0d] done=%b ready=%b hi=%h required 1/1/0000", i, done, ready, hi);
         end
      end
      valid = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || acc !== 16'h0000) begin
         failures++;
         $display("FAIL alu_idle done=%b acc=%h required 0/0000", done, acc);
      end
   endtask

   task automatic test_mul();
      int low_cnt  = 0;
      int done_cnt = 0;
      int done_at  = 0;
      logic [15:0] hi_s = '0, lo_s = '0;
      logic [3:0]  fl_s = '0;
      op = 3'b101; a = 16'h1234; b = 16'h0100; valid = 1'b1;
      @(negedge clk);
      op = 3'b001; a = 16'h0001; b = 16'h0001;   // held during busy, must be ignored
      for (int n = 1; n <= 20; n++) begin
         if (!ready) low_cnt++;
         if (done) begin done_cnt++; done_at = n; end
         if (n == 18) begin hi_s = hi; lo_s = acc; fl_s = {v_f, n_f, z_f, c_f}; end
         if (n == 17) valid = 1'b0;
         @(negedge clk);
      end
      $display("mul 1234*0100 -> hi=%h lo=%h VNZC=%b ready_low=%0d done_at=%0d", hi_s, lo_s, fl_s, low_cnt, done_at);
      checks++;
      if (low_cnt != 17) begin
         failures++;
         $display("FAIL mul_ready_low got=%0d required=17", low_cnt);
      end
      checks++;
      if (done_at != 18 || done_cnt != 1) begin
         failures++;
         $display("FAIL mul_done_timing got cycle=%0d pulses=%0d required cycle=18 pulses=1", done_at, done_cnt);
      end
      checks++;
      if (hi_s !== 16'h0012 || lo_s !== 16'h3400) begin
         failures++;
         $display("FAIL mul_product got=%h_%h required=0012_3400", hi_s, lo_s);
      end
      checks++;
      if (fl_s !== 4'b1001) begin
         failures++;
         $display("FAIL mul_flags got VNZC=%b required=1001", fl_s);
      end
   endtask

   task automatic test_reset_mid_mul();
      int done_cnt = 0;
      op = 3'b101; a = 16'h1234; b = 16'h0100; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({acc, hi, done, v_f, n_f, z_f, c_f} !== 37'd0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_mul acc=%h hi=%h done=%b flags=%b%b%b%b ready=%b required all 0, ready=1",
                  acc, hi, done, v_f, n_f, z_f, c_f, ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checks++;
      if (done_cnt != 0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_no_done pulses=%0d ready=%b required 0/1", done_cnt, ready);
      end
      op = 3'b001; a = 16'h0002; b = 16'h0003; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      $display("add 0002+0003 after reset -> acc=%h done=%b", acc, done);
      checks++;
      if (acc !== 16'h0005 || done !== 1'b1 || c_f !== 1'b0) begin
         failures++;
         $display("FAIL add_after_reset acc=%h done=%b c=%b required 0005/1/0", acc, done, c_f);
      end
   endtask

   task automatic test_mul_disabled();
      int waited = 0;
      op = 3'b001; a = 16'hFFFF; b = 16'h0001; valid = 1'b1;
      @(negedge clk);
      op = 3'b101; a = 16'h0003; b = 16'h0004;
      @(negedge clk);
      valid = 1'b0;
      $display("nomul mul 0003*0004 -> acc=%h VNZC=%b%b%b%b done=%b ready=%b", acc_d, v_d, n_d, z_d, c_d, done_d, ready_d);
      checks++;
      if (acc_d !== 16'h0000 || hi_d !== 16'h0000 || {v_d, n_d, z_d, c_d} !== 4'b0011) begin
         failures++;
         $display("FAIL nomul_unchanged acc=%h hi=%h VNZC=%b%b%b%b required 0000/0000/0011",
                  acc_d, hi_d, v_d, n_d, z_d, c_d);
      end
      checks++;
      if (done_d !== 1'b1 || ready_d !== 1'b1) begin
         failures++;
         $display("FAIL nomul_done done=%b ready=%b required 1/1", done_d, ready_d);
      end
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL mul_busy_ready got=%b required=0", ready);
      end
      @(negedge clk);
      checks++;
      if (done_d !== 1'b0) begin
         failures++;
         $display("FAIL nomul_done_pulse got=%b required=0", done_d);
      end
      while (!done && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      $display("mul 0003*0004 -> hi=%h lo=%h VNZC=%b%b%b%b", hi, acc, v_f, n_f, z_f, c_f);
      checks++;
      if (!done || acc !== 16'h000C || hi !== 16'h0000 || {v_f, n_f, z_f, c_f} !== 4'b0000) begin
         failures++;
         $display("FAIL mul_small done=%b hi=%h lo=%h VNZC=%b%b%b%b required 1/0000/000C/0000",
                  done, hi, acc, v_f, n_f, z_f, c_f);
      end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_mul();
      test_reset_mid_mul();
      test_mul_disabled();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
